// File: rtl/door_motor_ctrl.sv
// door_motor_ctrl
//   Reversible garage-door motor controller. Takes a push-button, two limit
//   switches and an obstruction sensor (all already debounced) and produces
//   registered raise/lower commands for the motor driver stage.
//   It reacts only to the rising edge of the button. It can stop mid-travel,
//   auto-reverses a closing door on obstruction, and holds both motor outputs
//   low for a dead time before any direction reversal. A run-time watchdog
//   latches a fault that only fault_clr or reset can leave.
//
// Parameters
//   RUN_TIMEOUT  cycles a motor output may stay high before FAULT (2 .. 2**CNT_W-1)
//   DEAD_CYCLES  cycles both motors are held low before a reversal (1 .. 2**CNT_W-1)
//   CNT_W        width of the shared cycle counter
//
// Ports
//   clk            clock, rising edge
//   rst_n          synchronous reset, active low
//   activate       push button level; only its rising edge acts
//   up_limit       door fully open
//   dn_limit       door fully closed
//   obstruct       obstruction sensor, active high
//   fault_clr      single-cycle fault acknowledge
//   motor_up_q     registered raise command
//   motor_dn_q     registered lower command
//   fault_q        registered, high while in FAULT
//   control_state  registered current state encoding

module door_motor_ctrl #(
  parameter int unsigned RUN_TIMEOUT = 64,
  parameter int unsigned DEAD_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       activate,
  input  logic       up_limit,
  input  logic       dn_limit,
  input  logic       obstruct,
  input  logic       fault_clr,
  output logic       motor_up_q,
  output logic       motor_dn_q,
  output logic       fault_q,
  output logic [2:0] control_state
);

  typedef enum logic [2:0] {
    S_RESOLVE   = 3'd0,
    S_IDLE_UP   = 3'd1,
    S_MOVING_DN = 3'd2,
    S_IDLE_DN   = 3'd3,
    S_MOVING_UP = 3'd4,
    S_STOPPED   = 3'd5,
    S_PAUSE     = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  // The counter reads 0 during the first cycle in a state, so the last
  // permitted cycle is reached when it reads LIMIT-1.
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  // Saturating increment so a very long dwell cannot wrap back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + CNT_ONE;
  endfunction

  function automatic logic is_timed(input state_t s);
    return (s == S_MOVING_UP) || (s == S_MOVING_DN) || (s == S_PAUSE);
  endfunction

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last_up_q;    // last travel direction: 1 = up, 0 = down
  logic             last_up_nxt;
  logic             tgt_up_q;     // direction to take when PAUSE ends
  logic             tgt_up_nxt;
  logic             act_d;
  logic             act_edge;
  logic             run_done;
  logic             dead_done;

  assign act_edge      = activate & ~act_d;
  assign run_done      = (cnt_q >= RUN_LAST);
  assign dead_done     = (cnt_q >= DEAD_LAST);
  assign control_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RESOLVE;
      cnt_q      <= '0;
      last_up_q  <= 1'b0;
      tgt_up_q   <= 1'b0;
      act_d      <= 1'b1;   // a button held through reset is not an edge
      motor_up_q <= 1'b0;
      motor_dn_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      last_up_q  <= last_up_nxt;
      tgt_up_q   <= tgt_up_nxt;
      act_d      <= activate;
      motor_up_q <= (state_nxt == S_MOVING_UP);
      motor_dn_q <= (state_nxt == S_MOVING_DN);
      fault_q    <= (state_nxt == S_FAULT);
    end
  end

  always_comb begin
    state_nxt   = state_q;
    last_up_nxt = last_up_q;
    tgt_up_nxt  = tgt_up_q;

    if (state_q == S_MOVING_DN) last_up_nxt = 1'b0;
    if (state_q == S_MOVING_UP) last_up_nxt = 1'b1;

    // Both limits closed at once means a broken switch or wiring.
    if (up_limit && dn_limit && (state_q != S_FAULT)) begin
      state_nxt = S_FAULT;
    end else begin
      unique case (state_q)
        S_RESOLVE: begin
          if (up_limit) begin
            state_nxt = S_IDLE_UP;
          end else if (dn_limit) begin
            state_nxt = S_IDLE_DN;
          end else begin
            // Position unknown: treat as having gone down so the next press raises.
            state_nxt   = S_STOPPED;
            last_up_nxt = 1'b0;
          end
        end
        S_IDLE_UP: begin
          if (act_edge && !obstruct) state_nxt = S_MOVING_DN;
        end
        S_IDLE_DN: begin
          if (act_edge) state_nxt = S_MOVING_UP;
        end
        S_MOVING_DN: begin
          if (dn_limit) begin
            state_nxt = S_IDLE_DN;
          end else if (obstruct) begin
            state_nxt  = S_PAUSE;
            tgt_up_nxt = 1'b1;
          end else if (act_edge) begin
            state_nxt = S_STOPPED;
          end else if (run_done) begin
            state_nxt = S_FAULT;
          end
        end
        S_MOVING_UP: begin
          if (up_limit) begin
            state_nxt = S_IDLE_UP;
          end else if (act_edge) begin
            state_nxt = S_STOPPED;
          end else if (run_done) begin
            state_nxt = S_FAULT;
          end
        end
        S_STOPPED: begin
          if (act_edge) begin
            state_nxt  = S_PAUSE;
            tgt_up_nxt = ~last_up_q;
          end
        end
        S_PAUSE: begin
          if (dead_done) begin
            if (tgt_up_q) begin
              state_nxt = S_MOVING_UP;
            end else if (obstruct) begin
              state_nxt = S_STOPPED;
            end else begin
              state_nxt = S_MOVING_DN;
            end
          end
        end
        S_FAULT: begin
          if (fault_clr) state_nxt = S_RESOLVE;
        end
        default: state_nxt = S_RESOLVE;
      endcase
    end
  end

  // Shared counter: restarts on entry to a timed state, counts while in it.
  always_comb begin
    cnt_nxt = '0;
    if (is_timed(state_nxt)) begin
      if (state_nxt != state_q) begin
        cnt_nxt = '0;
      end else begin
        cnt_nxt = sat_inc(cnt_q);
      end
    end
  end

endmodule

// File: tb/tb_door_motor_ctrl.sv
// Bench for door_motor_ctrl: directed stimulus, a behavioural reference that
// tracks the door by named state and time-in-state, per-cycle comparison,
// and literal expectations at key points of the sequence.

module tb_door_motor_ctrl;

  localparam int RUN_TIMEOUT = 64;
  localparam int DEAD_CYCLES = 4;
  localparam int CNT_W       = 16;

  localparam int RESOLVE = 0, IDLE_UP = 1, MOVING_DN = 2, IDLE_DN = 3;
  localparam int MOVING_UP = 4, STOPPED = 5, PAUSE = 6, FAULT = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       activate = 1'b0;
  logic       up_limit = 1'b0;
  logic       dn_limit = 1'b0;
  logic       obstruct = 1'b0;
  logic       fault_clr = 1'b0;
  logic       motor_up_q;
  logic       motor_dn_q;
  logic       fault_q;
  logic [2:0] control_state;

  int checks = 0;
  int errors = 0;

  door_motor_ctrl #(
    .RUN_TIMEOUT(RUN_TIMEOUT),
    .DEAD_CYCLES(DEAD_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .activate     (activate),
    .up_limit     (up_limit),
    .dn_limit     (dn_limit),
    .obstruct     (obstruct),
    .fault_clr    (fault_clr),
    .motor_up_q   (motor_up_q),
    .motor_dn_q   (motor_dn_q),
    .fault_q      (fault_q),
    .control_state(control_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which state the door should be in, how many whole
  // cycles it has already spent there, and the remembered directions.
  int m_state = RESOLVE;
  int m_age = 0;
  bit m_prev_act = 1'b1;
  bit m_last_up = 1'b0;
  bit m_tgt_up = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int  nxt;
    bit  m_edge;
    if (!rst_n) begin
      m_state    = RESOLVE;
      m_age      = 0;
      m_prev_act = 1'b1;
      m_last_up  = 1'b0;
      m_tgt_up   = 1'b0;
      m_valid    = 1'b1;
    end else begin
      m_edge = activate && !m_prev_act;
      nxt = m_state;
      if (m_state == MOVING_DN) m_last_up = 1'b0;
      if (m_state == MOVING_UP) m_last_up = 1'b1;
      if (up_limit && dn_limit && m_state != FAULT) begin
        nxt = FAULT;
      end else if (m_state == RESOLVE) begin
        if (up_limit) nxt = IDLE_UP;
        else if (dn_limit) nxt = IDLE_DN;
        else begin nxt = STOPPED; m_last_up = 1'b0; end
      end else if (m_state == IDLE_UP) begin
        if (m_edge && !obstruct) nxt = MOVING_DN;
      end else if (m_state == IDLE_DN) begin
        if (m_edge) nxt = MOVING_UP;
      end else if (m_state == MOVING_DN) begin
        if (dn_limit) nxt = IDLE_DN;
        else if (obstruct) begin nxt = PAUSE; m_tgt_up = 1'b1; end
        else if (m_edge) nxt = STOPPED;
        else if (m_age + 1 >= RUN_TIMEOUT) nxt = FAULT;
      end else if (m_state == MOVING_UP) begin
        if (up_limit) nxt = IDLE_UP;
        else if (m_edge) nxt = STOPPED;
        else if (m_age + 1 >= RUN_TIMEOUT) nxt = FAULT;
      end else if (m_state == STOPPED) begin
        if (m_edge) begin nxt = PAUSE; m_tgt_up = !m_last_up; end
      end else if (m_state == PAUSE) begin
        if (m_age + 1 >= DEAD_CYCLES) begin
          if (m_tgt_up) nxt = MOVING_UP;
          else if (obstruct) nxt = STOPPED;
          else nxt = MOVING_DN;
        end
      end else if (m_state == FAULT) begin
        if (fault_clr) nxt = RESOLVE;
      end
      m_prev_act = activate;
      m_age = (nxt == m_state) ? m_age + 1 : 0;
      m_state = nxt;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_state", 32'(control_state), 32'(m_state));
      chk("model_up", 32'(motor_up_q), 32'(m_state == MOVING_UP));
      chk("model_dn", 32'(motor_dn_q), 32'(m_state == MOVING_DN));
      chk("model_fault", 32'(fault_q), 32'(m_state == FAULT));
      chk("model_excl", 32'(motor_up_q & motor_dn_q), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    up_limit = 1'b1;
    step(); step();
    chk("rst_state", 32'(control_state), 32'd0);
    chk("rst_outs", {29'd0, motor_up_q, motor_dn_q, fault_q}, 32'd0);

    rst_n = 1'b1;
    step();
    chk("resolve_up", 32'(control_state), 32'd1);
    step(); step();
    activate = 1'b1;
    step();
    chk("close_dn", 32'(motor_dn_q), 32'd1);
    chk("close_state", 32'(control_state), 32'd2);
    activate = 1'b0;

    up_limit = 1'b0;
    step(); step(); step();
    dn_limit = 1'b1;
    activate = 1'b1;          // limit and press together: limit wins
    step();
    chk("closed_dn", 32'(motor_dn_q), 32'd0);
    chk("closed_state", 32'(control_state), 32'd3);
    chk("closed_fault", 32'(fault_q), 32'd0);
    step(); step(); step();   // button held: no new edge
    chk("held_state", 32'(control_state), 32'd3);
    chk("held_up", 32'(motor_up_q), 32'd0);
    activate = 1'b0;
    step();
    activate = 1'b1;
    step();
    chk("open_up", 32'(motor_up_q), 32'd1);
    chk("open_state", 32'(control_state), 32'd4);
    activate = 1'b0;
    dn_limit = 1'b0;
    step(); step();
    up_limit = 1'b1;
    step();
    chk("opened_state", 32'(control_state), 32'd1);

    obstruct = 1'b1;
    activate = 1'b1;
    step();
    chk("obst_idle", 32'(control_state), 32'd1);
    activate = 1'b0;
    obstruct = 1'b0;
    step();
    activate = 1'b1;
    step();
    chk("close2_state", 32'(control_state), 32'd2);
    activate = 1'b0;
    up_limit = 1'b0;
    step(); step();
    obstruct = 1'b1;
    step();
    chk("rev_dn", 32'(motor_dn_q), 32'd0);
    chk("rev_pause", 32'(control_state), 32'd6);
    obstruct = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rev_pause_hold", 32'(control_state), 32'd6);
    end
    step();
    chk("rev_up", 32'(motor_up_q), 32'd1);
    chk("rev_state", 32'(control_state), 32'd4);

    step();
    activate = 1'b1;
    step();
    chk("stop_state", 32'(control_state), 32'd5);
    activate = 1'b0;
    step();
    activate = 1'b1;
    step();
    chk("p2_state", 32'(control_state), 32'd6);
    activate = 1'b0;
    obstruct = 1'b1;
    step(); step(); step();
    step();
    chk("pause_obst_stop", 32'(control_state), 32'd5);
    obstruct = 1'b0;
    activate = 1'b1;
    step();
    activate = 1'b0;
    step(); step(); step();
    step();
    chk("p3_dn_state", 32'(control_state), 32'd2);
    chk("p3_dn", 32'(motor_dn_q), 32'd1);

    n = 0;
    while (motor_dn_q === 1'b1 && n < 200) begin
      n++;
      step();
    end
    chk("timeout_len", 32'(n), 32'(RUN_TIMEOUT));
    chk("timeout_fault", 32'(fault_q), 32'd1);
    chk("timeout_state", 32'(control_state), 32'd7);
    activate = 1'b1;
    obstruct = 1'b1;
    step();
    chk("fault_ignore", 32'(control_state), 32'd7);
    activate = 1'b0;
    obstruct = 1'b0;
    step();
    fault_clr = 1'b1;
    step();
    chk("clr_resolve", 32'(control_state), 32'd0);
    fault_clr = 1'b0;
    step();
    chk("clr_stopped", 32'(control_state), 32'd5);
    activate = 1'b1;
    step();
    activate = 1'b0;
    step(); step(); step();
    step();
    chk("after_clr_up", 32'(motor_up_q), 32'd1);
    up_limit = 1'b1;
    step();
    chk("idle_up2", 32'(control_state), 32'd1);
    dn_limit = 1'b1;
    step();
    chk("both_lim_fault", 32'(fault_q), 32'd1);
    chk("both_lim_state", 32'(control_state), 32'd7);

    up_limit = 1'b0;
    dn_limit = 1'b0;
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    step();
    activate = 1'b1;
    step();
    activate = 1'b0;
    step(); step(); step(); step();
    step();
    chk("pre_rst_up", 32'(motor_up_q), 32'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_outs", {29'd0, motor_up_q, motor_dn_q, fault_q}, 32'd0);
    chk("mid_rst_state", 32'(control_state), 32'd0);
    rst_n = 1'b1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/door_motor_ctrl.md
Name: door_motor_ctrl

Overview:
Parametrised successor to the single-channel garage-door motor FSM. Drives one reversible motor (up/down) from a push-button activate input and two limit switches. Adds activate edge detection, mid-travel stop, obstruction auto-reverse, a dead-time pause before any direction reversal, a run-time watchdog with a latched fault, and fault clear. Sits between the debounced panel/sensor inputs and the motor driver stage.

Parameters:
RUN_TIMEOUT, 64, max cycles a motor output may stay high before FAULT; legal range is 2 to 2**CNT_W-1.
DEAD_CYCLES, 4, cycles both motor outputs held low before a reversal; legal range is 1 to 2**CNT_W-1.
CNT_W, 16, width of the shared internal cycle counter.

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
activate  input  1  push button (level); only its rising edge acts
up_limit  input  1  door fully open switch
dn_limit  input  1  door fully closed switch
obstruct  input  1  obstruction sensor, active high
fault_clr  input  1  single-cycle fault acknowledge
motor_up_q  output  1  registered raise command
motor_dn_q  output  1  registered lower command
fault_q  output  1  registered, high while in FAULT
control_state  output  3  registered current state encoding

Behaviour:
- States and encodings: RESOLVE=0, IDLE_UP=1, MOVING_DN=2, IDLE_DN=3, MOVING_UP=4, STOPPED=5, PAUSE=6, FAULT=7.
- Reset (rst_n low at a clock edge): state is RESOLVE, all outputs are 0, the counter is 0, last_dir is DN, and the internal act_d flop is 1 so a held button is not taken as an edge.
- act_edge = activate & ~act_d. act_d updates every cycle.
- All outputs are registered and decoded from the next state. motor_up_q=1 only in MOVING_UP. motor_dn_q=1 only in MOVING_DN. fault_q=1 only in FAULT. Both motor outputs are never high together.
- Latency: an input sampled at edge N takes effect in the outputs after edge N.
- Global rule: up_limit & dn_limit both 1 in any state except FAULT goes to FAULT. This rule has the highest priority.
- RESOLVE:
  - up_limit only goes to IDLE_UP.
  - dn_limit only goes to IDLE_DN.
  - Neither goes to STOPPED with last_dir=DN, so the next move is up.
- IDLE_UP: act_edge & ~obstruct goes to MOVING_DN. With obstruct=1 the press is ignored.
- IDLE_DN: act_edge goes to MOVING_UP.
- MOVING_DN, priority order:
  1. dn_limit goes to IDLE_DN.
  2. obstruct goes to PAUSE with target UP.
  3. act_edge goes to STOPPED.
  4. timeout goes to FAULT.
  Set last_dir=DN.
- MOVING_UP, priority order:
  1. up_limit goes to IDLE_UP.
  2. act_edge goes to STOPPED.
  3. timeout goes to FAULT.
  obstruct is ignored. Set last_dir=UP.
- Limit beats activate when both occur in the same cycle.
- STOPPED: act_edge goes to PAUSE with target = opposite of last_dir.
- PAUSE: both motors are low for exactly DEAD_CYCLES cycles, then the state enters the target MOVING state. If obstruct is high at exit with target DN, the state goes to STOPPED instead.
- Counter:
  - Cleared on entry to MOVING_* or PAUSE.
  - Increments each cycle in those states.
  - Saturates at 2**CNT_W-1.
- Timeout: a MOVING state whose motor output has been high RUN_TIMEOUT cycles with no limit reached goes to FAULT. The motor output therefore pulses exactly RUN_TIMEOUT cycles.
- FAULT: motors are off. fault_clr goes to RESOLVE. activate, obstruct and limits are ignored. Only reset or fault_clr exits.
- Reset asserted mid-motion: motor outputs are 0 after that edge. No pause is applied.

Test Plan:
- Start with up_limit=1, dn_limit=0; release reset; pulse activate at cycle 3. Required: motor_dn_q=1 one cycle later, control_state=2. Then drop up_limit, raise dn_limit after 4 cycles. Required: motor_dn_q=0 next cycle, control_state=3, no fault.
- Hold activate high across the IDLE_DN arrival. Required: no second motion. Release and re-press: motor_up_q=1 one cycle after the edge.
- While MOVING_DN, assert obstruct for 1 cycle. Required: motor_dn_q=0 next cycle, state 6 for exactly 4 cycles, then motor_up_q=1 (state 4). Reach up_limit: state 1.
- While MOVING_UP, press activate. Required: STOPPED (5). Press again: PAUSE 4 cycles, then MOVING_DN.
- MOVING_DN with no limit ever. Required: motor_dn_q high exactly 64 cycles, then fault_q=1, state 7. Activate is ignored in FAULT. A fault_clr pulse goes to RESOLVE and then STOPPED (neither limit set).
- Drive up_limit=dn_limit=1 in IDLE_UP. Required: FAULT next cycle. Assert rst_n=0 mid MOVING_UP. Required: all outputs 0 after that edge.
